// File: rtl/return_address_stack_pkg.sv
// Shared definitions for the return-address predictor: default widths, the
// link-register encodings decode uses to qualify calls/returns, and the update-op encoding.
package return_address_stack_pkg;

    localparam int RAS_XLEN  = 32;
    localparam int RAS_DEPTH = 8;

    localparam logic [4:0] LINK_X1 = 5'd1;
    localparam logic [4:0] LINK_X5 = 5'd5;

    typedef enum logic [2:0] {
        RAS_NONE  = 3'd0,
        RAS_PUSH  = 3'd1,
        RAS_POP   = 3'd2,
        RAS_SWAP  = 3'd3,
        RAS_FLUSH = 3'd4
    } ras_op_e;

    // Decode-side helper: true when a register index is one of the link registers.
    function automatic logic is_link_reg(input logic [4:0] reg_idx);
        return (reg_idx == LINK_X1) || (reg_idx == LINK_X5);
    endfunction

endpackage

// File: rtl/return_address_stack.sv
// Circular-buffer return-address stack. The top entry is visible combinationally;
// pushes on a full stack silently overwrite the oldest entry and raise a one-cycle overflow.
module return_address_stack
    import return_address_stack_pkg::*;
#(
    parameter int DEPTH = RAS_DEPTH,
    parameter int XLEN  = RAS_XLEN
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push_en,
    input  logic [XLEN-1:0]          push_addr,
    input  logic                     pop_en,
    input  logic                     flush,
    output logic                     pred_valid,
    output logic [XLEN-1:0]          pred_addr,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [XLEN-1:0]  entry_q [DEPTH];
    logic [PTR_W-1:0] tos_q, tos_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             overflow_q, overflow_d;
    logic             wr_en_s;
    logic [PTR_W-1:0] wr_idx_s;
    logic             empty_s;
    logic             full_s;
    ras_op_e          op_s;

    assign empty_s = (count_q == CNT_W'(0));
    assign full_s  = (count_q == FULL_CNT);

    // Resolve the request priority: flush, then swap, then push, then a non-empty pop.
    always_comb begin
        op_s = RAS_NONE;
        if (flush) begin
            op_s = RAS_FLUSH;
        end else if (push_en && pop_en && !empty_s) begin
            op_s = RAS_SWAP;
        end else if (push_en) begin
            op_s = RAS_PUSH;
        end else if (pop_en && !empty_s) begin
            op_s = RAS_POP;
        end else begin
            op_s = RAS_NONE;
        end
    end

    // Next-state for pointer, occupancy, overflow pulse and the entry write port.
    always_comb begin
        tos_d      = tos_q;
        count_d    = count_q;
        overflow_d = 1'b0;
        wr_en_s    = 1'b0;
        wr_idx_s   = tos_q;
        case (op_s)
            RAS_FLUSH: begin
                tos_d   = PTR_W'(0);
                count_d = CNT_W'(0);
            end
            RAS_PUSH: begin
                tos_d      = tos_q + PTR_W'(1);
                wr_en_s    = 1'b1;
                wr_idx_s   = tos_q + PTR_W'(1);
                overflow_d = full_s;
                if (full_s) begin
                    count_d = count_q;
                end else begin
                    count_d = count_q + CNT_W'(1);
                end
            end
            RAS_SWAP: begin
                wr_en_s  = 1'b1;
                wr_idx_s = tos_q;
            end
            RAS_POP: begin
                tos_d   = tos_q - PTR_W'(1);
                count_d = count_q - CNT_W'(1);
            end
            default: begin
                tos_d   = tos_q;
                count_d = count_q;
            end
        endcase
    end

    // Control state with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tos_q      <= PTR_W'(0);
            count_q    <= CNT_W'(0);
            overflow_q <= 1'b0;
        end else begin
            tos_q      <= tos_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    // Entry storage needs no reset: occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            entry_q[wr_idx_s] <= push_addr;
        end
    end

    assign pred_addr  = entry_q[tos_q];
    assign pred_valid = !empty_s;
    assign count      = count_q;
    assign overflow   = overflow_q;

endmodule

// File: tb/tb_return_address_stack.sv
// Self-checking bench for return_address_stack: table-driven vectors through a
// scoreboard queue, plus a hand-written asynchronous-reset sequence.
module tb_return_address_stack;

    localparam int DEPTH = 8;
    localparam int XLEN  = 32;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic            clk;
    logic            rst;
    logic            push_en;
    logic [XLEN-1:0] push_addr;
    logic            pop_en;
    logic            flush;
    logic            pred_valid;
    logic [XLEN-1:0] pred_addr;
    logic [CW-1:0]   count;
    logic            overflow;

    return_address_stack #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
        .clk        (clk),
        .rst        (rst),
        .push_en    (push_en),
        .push_addr  (push_addr),
        .pop_en     (pop_en),
        .flush      (flush),
        .pred_valid (pred_valid),
        .pred_addr  (pred_addr),
        .count      (count),
        .overflow   (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic            push;
        logic            pop;
        logic            fl;
        logic [XLEN-1:0] addr;
        logic            exp_valid;
        logic [XLEN-1:0] exp_addr;
        logic [CW-1:0]   exp_count;
        logic            exp_ovf;
    } vec_t;

    typedef struct {
        logic            valid;
        logic [XLEN-1:0] addr;
        logic [CW-1:0]   cnt;
        logic            ovf;
    } exp_t;

    vec_t vecs[$];
    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    task automatic add(input logic p, input logic o, input logic f, input logic [XLEN-1:0] a,
                       input logic ev, input logic [XLEN-1:0] ea, input int ec, input logic eo);
        vec_t v;
        v.push = p; v.pop = o; v.fl = f; v.addr = a;
        v.exp_valid = ev; v.exp_addr = ea; v.exp_count = CW'(ec); v.exp_ovf = eo;
        vecs.push_back(v);
    endtask

    // Drive one cycle of stimulus (called at negedge), queue the expectation, compare after the edge.
    task automatic step(input vec_t v, input int idx);
        exp_t e;
        push_en   = v.push;
        pop_en    = v.pop;
        flush     = v.fl;
        push_addr = v.addr;
        e.valid = v.exp_valid; e.addr = v.exp_addr; e.cnt = v.exp_count; e.ovf = v.exp_ovf;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        push_en = 1'b0; pop_en = 1'b0; flush = 1'b0;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_empty at vector %0d", idx);
        end else begin
            e = exp_q.pop_front();
            check($sformatf("count[%0d]", idx), XLEN'(count), XLEN'(e.cnt));
            check($sformatf("valid[%0d]", idx), XLEN'(pred_valid), XLEN'(e.valid));
            check($sformatf("overflow[%0d]", idx), XLEN'(overflow), XLEN'(e.ovf));
            if (e.valid) begin
                check($sformatf("addr[%0d]", idx), pred_addr, e.addr);
            end
        end
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1; push_en = 1'b0; pop_en = 1'b0; flush = 1'b0; push_addr = '0;

        // Basic call/return nesting
        add(1, 0, 0, 32'h1004, 1, 32'h1004, 1, 0);
        add(1, 0, 0, 32'h2008, 1, 32'h2008, 2, 0);
        add(1, 0, 0, 32'h300C, 1, 32'h300C, 3, 0);
        add(0, 1, 0, 32'h0,    1, 32'h2008, 2, 0);
        add(0, 1, 0, 32'h0,    1, 32'h1004, 1, 0);
        add(0, 1, 0, 32'h0,    0, 32'h0,    0, 0);
        // Pops on an empty stack are ignored
        for (int i = 0; i < 3; i++) add(0, 1, 0, 32'h0, 0, 32'h0, 0, 0);
        add(1, 0, 0, 32'h44, 1, 32'h44, 1, 0);
        add(0, 1, 0, 32'h0,  0, 32'h0,  0, 0);
        // Overflow with wrap-around
        for (int i = 1; i <= 9; i++)
            add(1, 0, 0, 32'(i * 256), 1, 32'(i * 256), (i > 8) ? 8 : i, (i == 9) ? 1'b1 : 1'b0);
        for (int i = 1; i <= 7; i++)
            add(0, 1, 0, 32'h0, 1, 32'((9 - i) * 256), 8 - i, 0);
        add(0, 1, 0, 32'h0, 0, 32'h0, 0, 0);
        // Coroutine swap
        add(1, 0, 0, 32'hA0, 1, 32'hA0, 1, 0);
        add(1, 0, 0, 32'hB0, 1, 32'hB0, 2, 0);
        add(1, 1, 0, 32'hC0, 1, 32'hC0, 2, 0);
        add(0, 1, 0, 32'h0,  1, 32'hA0, 1, 0);
        add(0, 1, 0, 32'h0,  0, 32'h0,  0, 0);
        // Push+pop on an empty stack acts as a push
        add(1, 1, 0, 32'h5A, 1, 32'h5A, 1, 0);
        add(0, 1, 0, 32'h0,  0, 32'h0,  0, 0);
        // Flush outranks push and pop
        add(1, 0, 0, 32'h11, 1, 32'h11, 1, 0);
        add(1, 0, 0, 32'h22, 1, 32'h22, 2, 0);
        add(1, 0, 0, 32'h33, 1, 32'h33, 3, 0);
        add(1, 0, 0, 32'h44, 1, 32'h44, 4, 0);
        add(1, 0, 1, 32'h55, 0, 32'h0,  0, 0);
        add(1, 0, 0, 32'h66, 1, 32'h66, 1, 0);
        add(1, 1, 1, 32'h99, 0, 32'h0,  0, 0);
        // Flush on a full stack: no overflow pulse
        for (int i = 1; i <= 8; i++) add(1, 0, 0, 32'(i), 1, 32'(i), i, 0);
        add(1, 0, 1, 32'h77, 0, 32'h0, 0, 0);

        // Reset state
        @(negedge clk);
        #1;
        check("reset_count", XLEN'(count), XLEN'(0));
        check("reset_valid", XLEN'(pred_valid), XLEN'(0));
        check("reset_overflow", XLEN'(overflow), XLEN'(0));
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < vecs.size(); i++) step(vecs[i], i);

        // Asynchronous reset between edges discards live entries at once
        begin
            vec_t v;
            for (int i = 1; i <= 3; i++) begin
                v.push = 1'b1; v.pop = 1'b0; v.fl = 1'b0; v.addr = 32'(i * 16);
                v.exp_valid = 1'b1; v.exp_addr = 32'(i * 16); v.exp_count = CW'(i); v.exp_ovf = 1'b0;
                step(v, 1000 + i);
            end
            #2;
            rst = 1'b1;
            #1;
            check("async_rst_count", XLEN'(count), XLEN'(0));
            check("async_rst_valid", XLEN'(pred_valid), XLEN'(0));
            @(negedge clk);
            rst = 1'b0;
            v.push = 1'b1; v.pop = 1'b0; v.fl = 1'b0; v.addr = 32'h77;
            v.exp_valid = 1'b1; v.exp_addr = 32'h77; v.exp_count = CW'(1); v.exp_ovf = 1'b0;
            step(v, 2000);
            v.push = 1'b0; v.pop = 1'b1; v.addr = 32'h0;
            v.exp_valid = 1'b0; v.exp_addr = 32'h0; v.exp_count = CW'(0);
            step(v, 2001);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
